weighted_rr_arbiter: RTL and testbench
======================================

// Module: weighted_rr_arbiter
// PURPOSE
//  - N-requester round-robin arbiter with per-requester burst quota; successor to the fixed ring-counter arbiter.
//  - Searches for the next active requester, so idle lines are never granted and never waste a cycle.
//  - Holds a grant across a burst; releases on request drop or when the owner's quota is used up.
//  - Sits between N masters and one shared resource (bus port, memory bank, FIFO write side).
// PARAMETERS
//  N   7  number of requesters; N >= 2
//  QW  4  quota width in bits; per-requester burst length is 1..2^QW-1 cycles
//  IW  $clog2(N)  grant index width (localparam, derived)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  req          in   N     request vector; bit i high = requester i wants the resource
//  quota        in   N*QW  burst length of requester i in bits [i*QW +: QW]; 0 is treated as 1
//  grant        out  N     registered one-hot grant; all zero when idle
//  grant_valid  out  1     registered; high while any grant is asserted (== |grant)
//  grant_idx    out  IW    registered binary index of the owner; holds its last value when idle
//  lock         in   1     present only with WRR_ARB_LOCK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst high at posedge): state=IDLE, grant=0, grant_valid=0, grant_idx=0, ptr=0, cnt=0, qlat=0.
//  - Internal state:
//    - ptr: search start index.
//    - cnt: cycles used in the current burst (QW bits).
//    - qlat: quota latched at grant start.
//  - Search order:
//    - Scan req from ptr upward, wrapping modulo N; the first set bit wins.
//    - When the search starts after a release, ptr = owner+1 mod N, so the old owner is checked last.
//  - FSM IDLE:
//    - If |req at a posedge: go to GRANT; register the winner's grant and grant_idx; cnt=0; qlat=max(quota[w],1).
//    - Latency: req rising to grant high = 1 clock.
//    - If req==0: stay in IDLE with all outputs 0.
//  - FSM GRANT, evaluated at each posedge:
//    - release if req[owner]==0 (early release), or if cnt==qlat-1 (quota used up);
//    - on release, ptr <= owner+1 mod N, then run the search in the same edge:
//      - a winner exists: new grant registered at that same edge, cnt=0, qlat reloaded; no idle bubble;
//      - no winner: go to IDLE, grant=0, grant_valid=0;
//    - otherwise stay in GRANT; cnt <= cnt+1; grant is unchanged.
//  - A burst counts cycles with grant high (owner may deassert mid-burst). Granted cycles per burst = min(qlat, cycles req held).
//  - Quota expiry with the owner as the only requester: the owner re-wins at the same edge; grant stays high; cnt restarts at 0.
//  - New requests arriving during a burst never preempt the owner.
//  - Changes to quota[owner] during a burst are ignored until the next grant (qlat is latched).
//  - Simultaneous requests: the lowest index at or after ptr (with wrap) wins. Requesters are served in rotation with no starvation.
//  - rst asserted mid-burst: all outputs are 0 at the next edge; arbitration restarts from index 0.
//  - Invariants: grant is at most one-hot; grant_valid == |grant; grant[grant_idx]==1 whenever grant_valid is high.
// CONFIGURATION
//  - WRR_ARB_LOCK_EN defined:
//    - adds input lock;
//    - while lock==1 and req[owner]==1, quota expiry is suppressed and cnt saturates at qlat-1;
//    - the owner keeps the grant until req[owner] drops;
//    - lock has no effect in IDLE and never blocks release on request drop.
//  - WRR_ARB_LOCK_EN undefined: no lock port; bursts always end at quota.
// TESTING  (N=4, QW=4 unless noted)
//  - Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, grant_idx=0 throughout. First grant after rst drops is 4'b0001.
//  - Sparse rotation: quota=1 all, req=4'b1010 held -> grant sequence 0010,1000,0010,1000; requesters 0 and 2 never granted.
//  - Burst quota: quota={1,1,1,3} (req0 quota 3), req=4'b0011 held -> 0001 for 3 cycles, then 0010 for 1 cycle, repeating; no zero cycles.
//  - Early release: req0 quota 5, req0 drops after 2 granted cycles, req2 high -> grant 0100 at the edge that sees req0 low.
//  - Single requester plus reset mid-burst: only req3 high, quota 2 -> grant stays 1000 continuously. Reset mid-burst -> 0 next cycle, then 1000 again.
//  - Lock (WRR_ARB_LOCK_EN): req0 quota 2 with lock=1, req1 also high -> 0001 held for 6 cycles until req0 drops, then 0010.

Source files
------------

// File: rtl/weighted_rr_arbiter_if.sv
// weighted_rr_arbiter_if: request/quota/grant bundle between N masters and the arbiter
interface weighted_rr_arbiter_if #(
   parameter int N  = 7,
   parameter int QW = 4
);
   localparam int IW = $clog2(N);
   logic [N-1:0]    req;
   logic [N*QW-1:0] quota;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IW-1:0]   grant_idx;
   modport master (output req, quota, input grant, grant_valid, grant_idx);
   modport slave  (input req, quota, output grant, grant_valid, grant_idx);
endinterface

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: round-robin arbiter with per-requester burst quota; WRR_ARB_LOCK_EN adds a lock input
module weighted_rr_arbiter #(
   parameter int N  = 7,
   parameter int QW = 4
) (
   input  logic clk,
   input  logic rst,
`ifdef WRR_ARB_LOCK_EN
   input  logic lock,
`endif
   weighted_rr_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t        state;
   logic [IW-1:0] ptr;
   logic [QW-1:0] cnt;
   logic [QW-1:0] qlat;
   logic          last;
   logic          locked;
   logic          rel;
   logic [IW-1:0] nxt;
   logic [IW-1:0] start;
   logic          found;
   logic [IW-1:0] win;
   logic [QW-1:0] wq;
`ifdef WRR_ARB_LOCK_EN
   assign locked = lock && bus.req[bus.grant_idx];
`else
   assign locked = 1'b0;
`endif
   assign last  = cnt == qlat - QW'(1);
   assign rel   = state == GRANT && (!bus.req[bus.grant_idx] || (last && !locked));
   assign nxt   = bus.grant_idx == IW'(N - 1) ? '0 : bus.grant_idx + IW'(1);
   assign start = rel ? nxt : ptr;
   assign wq    = bus.quota[int'(win)*QW +: QW];
   // first active requester at or after start, wrapping modulo N
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (bus.req[(int'(start) + k) % N]) begin
            found = 1'b1;
            win   = IW'((int'(start) + k) % N);
         end
      end
   end
   // arbitration FSM: grant on search win, hold through the burst, re-search on release
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.grant       <= '0;
         bus.grant_valid <= 1'b0;
         bus.grant_idx   <= '0;
         ptr             <= '0;
         cnt             <= '0;
         qlat            <= '0;
      end else if (state == IDLE || rel) begin
         if (rel) ptr <= nxt;
         if (found) begin
            state           <= GRANT;
            bus.grant       <= {{(N-1){1'b0}}, 1'b1} << win;
            bus.grant_valid <= 1'b1;
            bus.grant_idx   <= win;
            cnt             <= '0;
            qlat            <= wq == '0 ? QW'(1) : wq;
         end else begin
            state           <= IDLE;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
         end
      end else begin
         cnt <= (locked && last) ? cnt : cnt + QW'(1);
      end
   end
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: randomized and directed check of weighted_rr_arbiter against a behavioural model
module tb_weighted_rr_arbiter;
   localparam int N  = 4;
   localparam int QW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   m_owner;
   int   m_used;
   int   m_lim;
   int   m_ptr;
   int   m_idx;
   weighted_rr_arbiter_if #(.N(N), .QW(QW)) bus ();
`ifdef WRR_ARB_LOCK_EN
   logic lock = 1'b0;
   weighted_rr_arbiter #(.N(N), .QW(QW)) dut (.clk(clk), .rst(rst), .lock(lock), .bus(bus.slave));
`else
   weighted_rr_arbiter #(.N(N), .QW(QW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int qof(input logic [N*QW-1:0] q, input int i);
      logic [QW-1:0] v;
      v = q[i*QW +: QW];
      return v == 0 ? 1 : int'(v);
   endfunction

   // behavioural model: owner keeps the resource for min(quota, request time) granted cycles
   task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*QW-1:0] q);
      bit pick;
      if (r) begin
         m_owner = -1; m_used = 0; m_lim = 0; m_ptr = 0; m_idx = 0;
         return;
      end
      pick = (m_owner < 0);
      if (m_owner >= 0) begin
         m_used++;
         if (!rq[m_owner] || m_used >= m_lim) begin
            m_ptr = (m_owner + 1) % N;
            pick  = 1'b1;
         end
      end
      if (pick) begin
         m_owner = -1;
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         end
         if (m_owner >= 0) begin
            m_used = 0;
            m_lim  = qof(q, m_owner);
            m_idx  = m_owner;
         end
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*QW-1:0] q);
      @(negedge clk);
      rst = r; bus.req = rq; bus.quota = q;
      @(posedge clk);
      model_edge(r, rq, q);
      #1;
      chk("grant", 32'(bus.grant), m_owner >= 0 ? 32'(1 << m_owner) : 32'd0);
      chk("grant_valid", 32'(bus.grant_valid), m_owner >= 0 ? 32'd1 : 32'd0);
      chk("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
   endtask

   initial begin
      logic [N-1:0]    rq;
      logic [N*QW-1:0] q;
      logic [N-1:0]    seq_sparse [4];
      logic [N-1:0]    seq_burst [8];
      seq_sparse = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      seq_burst  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      bus.req = '0; bus.quota = '0;
      step(1'b1, 4'b1111, 16'h1111);
      chk("reset_grant", 32'(bus.grant), 32'd0);
      step(1'b1, 4'b1111, 16'h1111);
      chk("reset_idx", 32'(bus.grant_idx), 32'd0);
      step(1'b0, 4'b1111, 16'h1111);
      chk("first_grant", 32'(bus.grant), 32'b0001);
      step(1'b1, 4'b0000, 16'h1111);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b1010, 16'h1111);
         chk("sparse_rot", 32'(bus.grant), 32'(seq_sparse[i]));
      end
      step(1'b1, 4'b0000, 16'h1113);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'b0011, 16'h1113);
         chk("burst_quota", 32'(bus.grant), 32'(seq_burst[i]));
      end
      step(1'b1, 4'b0000, 16'h1115);
      step(1'b0, 4'b0101, 16'h1115);
      step(1'b0, 4'b0101, 16'h1115);
      step(1'b0, 4'b0100, 16'h1115);
      chk("early_release", 32'(bus.grant), 32'b0100);
      step(1'b1, 4'b0000, 16'h2111);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b1000, 16'h2111);
         chk("single_req", 32'(bus.grant), 32'b1000);
      end
      step(1'b1, 4'b1000, 16'h2111);
      chk("mid_reset", 32'(bus.grant), 32'd0);
      step(1'b0, 4'b1000, 16'h2111);
      chk("after_reset", 32'(bus.grant), 32'b1000);
      step(1'b0, 4'b1111, 16'h0000);
      rq = 4'b1111;
      q  = 16'h0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rq = N'($urandom);
         if ($urandom_range(0, 7) == 0) q = {4{QW'($urandom_range(0, 4))}} ^ 16'($urandom & 32'h3333);
         step($urandom_range(0, 59) == 0, rq, q);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
